// File: rtl/target_emulator.sv
`timescale 1ns/1ps
// target_emulator: stand-in glitch victim driven by the glitcher's target-side pins.
// Measures every target_clk phase in clk cycles. A too-short phase inside the
// vulnerable window is a successful fault; one during boot is a crash.
//
// state   | meaning
// --------+---------------------------------------------------------------
// OFF     | target unpowered, everything idle
// RESET   | powered, target reset pin asserted
// BOOT    | counting target_clk rising edges towards the vulnerable window
// WINDOW  | vulnerable window open, ready high
// SUCCESS | glitch landed inside the window, held until OFF/RESET
// DONE    | window closed with no glitch, held until OFF/RESET
// CRASH   | glitch landed during boot, held until OFF/RESET
module target_emulator #(
  parameter int MIN_PHASE         = 3,
  parameter int PHASE_W           = 8,
  parameter int BOOT_EDGES        = 1000,
  parameter int WINDOW_EDGES      = 64,
  parameter bit RESET_ACTIVE_HIGH = 1'b1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             target_clk,
  input  logic             target_reset,
  input  logic             target_power,
  output logic             ready,
  output logic             success,
  output logic             crashed,
  output logic [CNT_W-1:0] glitch_count,
  output logic [2:0]       state_o
);

  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_RESET   = 3'd1;
  localparam logic [2:0] ST_BOOT    = 3'd2;
  localparam logic [2:0] ST_WINDOW  = 3'd3;
  localparam logic [2:0] ST_SUCCESS = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [2:0] ST_CRASH   = 3'd6;

  localparam logic [PHASE_W-1:0] PHASE_MAX = '1;
  localparam logic [PHASE_W-1:0] PHASE_MIN = PHASE_W'(MIN_PHASE);
  localparam logic [CNT_W-1:0]   BOOT_LAST = CNT_W'(BOOT_EDGES - 1);
  localparam logic [CNT_W-1:0]   WIN_LAST  = CNT_W'(WINDOW_EDGES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  // [0],[1] form the synchronizer; [2] is the previous synced value for edge detect
  logic [2:0]         tclk_sync;
  logic [1:0]         trst_sync;
  logic [1:0]         pwr_sync;
  logic               tclk_edge;
  logic               tclk_rise;
  logic               reset_act;
  logic               power_on;

  logic [PHASE_W-1:0] phase_cnt;
  logic               phase_valid;
  logic               glitch_det;
  logic               rise_det;

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [CNT_W-1:0]   edge_cnt;
  logic               enter_idle;
  logic               count_clear;
  logic               count_en;

  assign tclk_edge = tclk_sync[1] ^ tclk_sync[2];
  assign tclk_rise = tclk_sync[1] & ~tclk_sync[2];
  assign reset_act = RESET_ACTIVE_HIGH ? trst_sync[1] : ~trst_sync[1];
  assign power_on  = pwr_sync[1];
  assign state_o   = state;

  // Bring the three asynchronous target pins into the clk domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tclk_sync <= '0;
      trst_sync <= '0;
      pwr_sync  <= '0;
    end else begin
      tclk_sync <= {tclk_sync[1:0], target_clk};
      trst_sync <= {trst_sync[0], target_reset};
      pwr_sync  <= {pwr_sync[0], target_power};
    end
  end

  // Phase length in clk cycles; restarts at 1 on every synced target_clk edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_cnt <= '0;
    end else if (tclk_edge) begin
      phase_cnt <= PHASE_W'(1);
    end else if (phase_cnt != PHASE_MAX) begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

  // Judge each edge; rise_det is registered so it lines up with glitch_det
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      glitch_det  <= 1'b0;
      rise_det    <= 1'b0;
      phase_valid <= 1'b0;
    end else begin
      glitch_det <= tclk_edge && phase_valid && (phase_cnt < PHASE_MIN);
      rise_det   <= tclk_rise;
      // The phase leading into the first edge after OFF/RESET is meaningless
      if (enter_idle) begin
        phase_valid <= 1'b0;
      end else if (tclk_edge) begin
        phase_valid <= 1'b1;
      end
    end
  end

  // Next-state decode: power loss beats target reset, which beats everything else
  always_comb begin
    state_nxt = state;
    if (!power_on) begin
      state_nxt = ST_OFF;
    end else if (reset_act && (state != ST_OFF)) begin
      state_nxt = ST_RESET;
    end else begin
      case (state)
        ST_OFF:     state_nxt = ST_RESET;
        ST_RESET:   state_nxt = ST_BOOT;
        ST_BOOT: begin
          if (glitch_det) begin
            state_nxt = ST_CRASH;
          end else if (rise_det && (edge_cnt == BOOT_LAST)) begin
            state_nxt = ST_WINDOW;
          end
        end
        ST_WINDOW: begin
          // A glitch on the closing edge still counts as a hit
          if (glitch_det) begin
            state_nxt = ST_SUCCESS;
          end else if (rise_det && (edge_cnt == WIN_LAST)) begin
            state_nxt = ST_DONE;
          end
        end
        ST_SUCCESS: state_nxt = ST_SUCCESS;
        ST_DONE:    state_nxt = ST_DONE;
        ST_CRASH:   state_nxt = ST_CRASH;
        default:    state_nxt = ST_OFF;
      endcase
    end
  end

  assign enter_idle  = (state_nxt != state) &&
                       ((state_nxt == ST_OFF) || (state_nxt == ST_RESET));
  assign count_clear = enter_idle || ((state == ST_RESET) && (state_nxt == ST_BOOT));
  assign count_en    = glitch_det && (state != ST_OFF) && (state != ST_RESET);

  // State register plus the per-state rising-edge counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_OFF;
      edge_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        edge_cnt <= '0;
      end else if (rise_det && ((state == ST_BOOT) || (state == ST_WINDOW))) begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

  // Saturating glitch tally, cleared whenever the target restarts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      glitch_count <= '0;
    end else if (count_clear) begin
      glitch_count <= '0;
    end else if (count_en && (glitch_count != CNT_MAX)) begin
      glitch_count <= glitch_count + 1'b1;
    end
  end

  // Status outputs registered from the next state so they move with state_o
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready   <= 1'b0;
      success <= 1'b0;
      crashed <= 1'b0;
    end else begin
      ready   <= (state_nxt == ST_WINDOW);
      success <= (state_nxt == ST_SUCCESS);
      crashed <= (state_nxt == ST_CRASH);
    end
  end

endmodule
